// File: rtl/bsg_cgol_input_packer.sv
// Serial-to-board deserializer for the CGOL accelerator: packs in_width_p-bit words into a
// {cells, frame-count} packet. Optional frame-count check is enabled by BSG_CGOL_INPUT_CHECK_EN.
module bsg_cgol_input_packer #(
    parameter int board_width_p     = 8,
    parameter int max_game_length_p = 16,
    parameter int in_width_p        = 64,
    localparam int cells_lp = board_width_p * board_width_p,
    localparam int glw_lp   = (max_game_length_p <= 1) ? 1 : $clog2(max_game_length_p),
    localparam int words_lp = (cells_lp + glw_lp + in_width_p - 1) / in_width_p
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [in_width_p-1:0] data_i,
    input  logic                  v_i,
    output logic                  ready_o,
    output logic [cells_lp-1:0]   data_o,
    output logic [glw_lp-1:0]     frames_o,
    output logic                  v_o,
    input  logic                  ready_i,
    output logic                  err_o
);

    localparam int pkt_w_lp   = cells_lp + glw_lp;
    localparam int pkt_bits_lp = words_lp * in_width_p;
    localparam int cnt_w_lp   = (words_lp > 1) ? $clog2(words_lp) : 1;
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(words_lp - 1);

    logic [in_width_p-1:0]  asm_r [words_lp];
    logic [cnt_w_lp-1:0]    cnt_r;
    logic                   asm_full_r;
    logic [pkt_w_lp-1:0]    out_r;
    logic                   out_v_r;
    logic                   err_r;

    logic [pkt_bits_lp-1:0] pkt;
    logic                   accept;
    logic                   last_word;
    logic                   xfer;
    logic                   pkt_ok;
    logic                   unused_pad;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pkt = '0;
        for (int k = 0; k < words_lp; k++) begin
            pkt[k*in_width_p +: in_width_p] = asm_r[k];
        end
    end

    // Pad bits of the last word are carried but never forwarded.
    assign unused_pad = ^pkt;

    assign xfer      = asm_full_r & (~out_v_r | ready_i);
    assign ready_o   = ~asm_full_r | xfer;
    assign accept    = v_i & ready_o;
    assign last_word = (cnt_r == last_cnt_lp);

`ifdef BSG_CGOL_INPUT_CHECK_EN
    localparam logic [glw_lp:0] max_frames_lp = (glw_lp + 1)'(max_game_length_p);
    logic [glw_lp-1:0] frames_in;

    assign frames_in = pkt[glw_lp-1:0];
    assign pkt_ok    = (frames_in != '0) && ({1'b0, frames_in} <= max_frames_lp);
`else
    assign pkt_ok = 1'b1;
`endif

    // NOTE: sequential state uses <= only; blocking assignments here would race with readers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r      <= '0;
            asm_full_r <= 1'b0;
            out_r      <= '0;
            out_v_r    <= 1'b0;
            err_r      <= 1'b0;
            // NOTE: the assembly buffer is cleared on reset so outputs never expose stale words.
            for (int k = 0; k < words_lp; k++) begin
                asm_r[k] <= '0;
            end
        end else begin
            err_r <= xfer & ~pkt_ok;

            if (accept) begin
                for (int k = 0; k < words_lp; k++) begin
                    if (cnt_r == cnt_w_lp'(k)) begin
                        asm_r[k] <= data_i;
                    end
                end
                cnt_r <= last_word ? '0 : cnt_r + cnt_w_lp'(1);
            end

            // A last word landing in the same cycle as the hand-off refills the buffer at once.
            if (accept && last_word) begin
                asm_full_r <= 1'b1;
            end else if (xfer) begin
                asm_full_r <= 1'b0;
            end

            if (xfer && pkt_ok) begin
                out_r   <= pkt[pkt_w_lp-1:0];
                out_v_r <= 1'b1;
            end else if (out_v_r && ready_i) begin
                out_v_r <= 1'b0;
            end
        end
    end

    assign v_o      = out_v_r;
    assign frames_o = out_r[glw_lp-1:0];
    assign data_o   = out_r[glw_lp +: cells_lp];
    assign err_o    = err_r;

endmodule

// File: tb/tb_bsg_cgol_input_packer.sv
// Self-checking bench for bsg_cgol_input_packer at default parameters (two 64-bit words per packet).
// A queue-based reference model predicts each delivered packet; BSG_CGOL_INPUT_CHECK_EN is honoured.
module tb_bsg_cgol_input_packer;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [63:0] data_i;
    logic        v_i;
    logic        ready_o;
    logic [63:0] data_o;
    logic [3:0]  frames_o;
    logic        v_o;
    logic        ready_i;
    logic        err_o;

    bsg_cgol_input_packer dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .data_i   (data_i),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .data_o   (data_o),
        .frames_o (frames_o),
        .v_o      (v_o),
        .ready_i  (ready_i),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;
    int out_count   = 0;
    int err_seen    = 0;
    int err_exp     = 0;
    int stalls      = 0;

    logic [67:0] exp_q [$];
    logic [63:0] word_q [$];
    logic        held_v = 1'b0;
    logic [67:0] held_pkt;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit frames_valid(input logic [3:0] f);
`ifdef BSG_CGOL_INPUT_CHECK_EN
        return (f != 4'd0) && (int'(f) <= 16);
`else
        return 1'b1;
`endif
    endfunction

    // Reference model: accepted words are grouped in pairs into a 128-bit packet whose low
    // 4 bits are the frame count and the next 64 bits the board.
    always @(negedge clk_i) begin
        logic [127:0] pkt;
        if (!reset_n_i) begin
            word_q.delete();
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_v", 128'(v_o), 128'd1);
                check("hold_pkt", 128'({data_o, frames_o}), 128'(held_pkt));
            end
            if (v_o && ready_i) begin
                out_count++;
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_pkt: observed %0h expected none", {data_o, frames_o});
                end
                if (exp_q.size() != 0) begin
                    check("pkt", 128'({data_o, frames_o}), 128'(exp_q.pop_front()));
                end
            end
            if (err_o) err_seen++;
            if (v_i && ready_o) begin
                word_q.push_back(data_i);
                if (word_q.size() == 2) begin
                    pkt = {word_q[1], word_q[0]};
                    word_q.delete();
                    if (frames_valid(pkt[3:0])) exp_q.push_back(pkt[67:0]);
                    else err_exp++;
                end
            end
            held_v   = v_o && !ready_i;
            held_pkt = {data_o, frames_o};
        end
    end

    task automatic send_word(input logic [63:0] w);
        bit acc;
        int n;
        data_i = w;
        v_i    = 1'b1;
        n      = 0;
        acc    = 1'b0;
        do begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end while (!acc && n < 200);
        stalls += n - 1;
        vectors++;
        assert (acc) else begin
            miscompares++;
            $error("FAIL send_timeout: observed ready_o=0 for %0d cycles expected accept", n);
        end
    endtask

    task automatic drain();
        int n;
        v_i     = 1'b0;
        ready_i = 1'b1;
        n       = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        repeat (3) @(posedge clk_i);
        #1;
        check("drain_left", 128'(exp_q.size()), 128'd0);
    endtask

    function automatic logic [63:0] rand_word();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        int base;
        int n;
        logic [63:0] w;

        reset_n_i = 1'b0;
        v_i       = 1'b0;
        ready_i   = 1'b0;
        data_i    = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_v_o", 128'(v_o), 128'd0);
        check("rst_data_o", 128'(data_o), 128'd0);
        check("rst_frames_o", 128'(frames_o), 128'd0);
        check("rst_ready_o", 128'(ready_o), 128'd1);
        check("rst_err_o", 128'(err_o), 128'd0);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Known packet and two-cycle latency.
        ready_i = 1'b1;
        send_word(64'h0123456789ABCDE5);
        send_word(64'h000000000000000A);
        v_i = 1'b0;
        check("t1_v_o_n1", 128'(v_o), 128'd0);
        @(posedge clk_i);
        #1;
        check("t1_v_o_n2", 128'(v_o), 128'd1);
        check("t1_frames", 128'(frames_o), 128'd5);
        check("t1_data", 128'(data_o), 128'hA0123456789ABCDE);
        @(posedge clk_i);
        #1;
        check("t1_v_o_after", 128'(v_o), 128'd0);

        // Back-pressure: two packets buffered, third is blocked until the core releases.
        base    = out_count;
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = rand_word();
            if (i % 2 == 0) w[3:0] = 4'($urandom_range(1, 15));
            send_word(w);
        end
        data_i = {rand_word()[63:4], 4'd9};
        v_i    = 1'b1;
        @(negedge clk_i);
        check("t2_ready_blocked", 128'(ready_o), 128'd0);
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        send_word(data_i);
        send_word(rand_word());
        drain();
        check("t2_count", 128'(out_count - base), 128'd3);

        // Sustained full-rate streaming.
        base   = out_count;
        stalls = 0;
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            w = rand_word();
            if (i % 2 == 0) w[3:0] = 4'($urandom_range(1, 15));
            send_word(w);
        end
        check("t3_stalls", 128'(stalls), 128'd0);
        drain();
        check("t3_count", 128'(out_count - base), 128'd10);

        // Reset mid-packet discards the partial word.
        send_word(rand_word());
        v_i       = 1'b0;
        reset_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        base = out_count;
        send_word({rand_word()[63:4], 4'd3});
        send_word(rand_word());
        v_i = 1'b0;
        n   = 0;
        while (!v_o && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("t4_v_o", 128'(v_o), 128'd1);
        check("t4_frames", 128'(frames_o), 128'd3);
        drain();
        check("t4_count", 128'(out_count - base), 128'd1);

        // Frame-count boundaries: zero, then valid counts.
        send_word({rand_word()[63:4], 4'd0});
        send_word(rand_word());
        send_word({rand_word()[63:4], 4'd15});
        send_word(rand_word());
        send_word({rand_word()[63:4], 4'd7});
        send_word(rand_word());
        drain();

        // Randomised traffic with gaps and back-pressure.
        for (int c = 0; c < 300; c++) begin
            v_i     = ($urandom_range(0, 3) != 0);
            data_i  = rand_word();
            ready_i = $urandom_range(0, 1) == 1;
            @(posedge clk_i);
            #1;
        end
        drain();

        check("err_count", 128'(err_seen), 128'(err_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
